game_flow_ctrl: RTL and testbench

Game-level sequencer between the SoC (USB keycodes, difficulty, reset button) and the video/note datapath (lane pass_up windows, lose_life, VS). Runs the IDLE/PLAY/WIN/LOSE state machine and detects key hits per lane. Keeps score and lives, and schedules note spawns per frame using a pseudo-random lane. Drives the score_val, win_game and lose_game inputs of the SoC.

---
 rtl/game_flow_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE/PLAY/WIN/LOSE, key hit detection,
// score/lives bookkeeping and per-frame note spawn scheduling.
module game_flow_ctrl #(
  parameter logic [7:0] KEY_L      = 8'h04,
  parameter logic [7:0] KEY_M      = 8'h16,
  parameter logic [7:0] KEY_R      = 8'h07,
  parameter logic [7:0] KEY_START  = 8'h2C,
  parameter int         LIVES      = 3,
  parameter int         HIT_PTS    = 10,
  parameter int         WIN_SCORE  = 500,
  parameter int         SPAWN_EASY = 60,
  parameter int         SPAWN_HARD = 30
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  input  logic       pass_up1,
  input  logic       pass_up2,
  input  logic       pass_up3,
  input  logic       lose_life,
  input  logic       vs,
  input  logic       reset_button,
  input  logic       difficulty,
  output logic [9:0] score_val,
  output logic [1:0] lives,
  output logic       win_game,
  output logic       lose_game,
  output logic       spawn,
  output logic [1:0] spawn_lane,
  output logic [1:0] state,
  output logic [2:0] hit_flash
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_WIN  = 2'b10,
    S_LOSE = 2'b11
  } state_t;

  localparam logic [1:0]  LIVES_V = 2'(LIVES);
  localparam logic [10:0] PTS_V   = 11'(HIT_PTS);
  localparam logic [9:0]  WIN_V   = 10'(WIN_SCORE);
  localparam logic [7:0]  IVL_E   = 8'(SPAWN_EASY - 1);
  localparam logic [7:0]  IVL_H   = 8'(SPAWN_HARD - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_kc0;
  logic [7:0] r_kc1;
  logic [7:0] r_kc2;
  logic [2:0] r_pu;
  logic       r_ll;
  logic       r_ll_d;
  logic       r_vs;
  logic       r_vs_d;
  logic       r_rb;
  logic [3:0] r_pres;
  logic [9:0] r_score;
  logic [1:0] r_lives;
  logic       r_win;
  logic       r_lose;
  logic       r_spawn;
  logic [1:0] r_lane;
  logic [2:0] r_flash;
  logic [7:0] r_lfsr;
  logic [7:0] r_fcnt;
  logic       r_diff;

  logic [3:0]  w_pres;
  logic [3:0]  w_press;
  logic        w_start;
  logic [2:0]  w_hit;
  logic [10:0] w_sum;
  logic [9:0]  w_score_n;
  logic        w_ll_edge;
  logic        w_tick;
  logic [7:0]  w_ivl;
  logic        w_fb;
  logic [1:0]  w_lane;

  function automatic logic f_has(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c,
    input logic [7:0] k
  );
    return (a == k) || (b == k) || (c == k);
  endfunction

  always_comb begin
    w_pres[0] = f_has(r_kc0, r_kc1, r_kc2, KEY_L);
    w_pres[1] = f_has(r_kc0, r_kc1, r_kc2, KEY_M);
    w_pres[2] = f_has(r_kc0, r_kc1, r_kc2, KEY_R);
    w_pres[3] = f_has(r_kc0, r_kc1, r_kc2, KEY_START);
  end

  assign w_press   = w_pres & ~r_pres;
  assign w_start   = w_press[3];
  assign w_hit     = w_press[2:0] & r_pu;
  assign w_ll_edge = r_ll & ~r_ll_d;
  assign w_tick    = r_vs_d & ~r_vs;
  assign w_ivl     = r_diff ? IVL_H : IVL_E;
  assign w_fb      = r_lfsr[7] ^ r_lfsr[5]
                   ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_lane    = (r_lfsr[1:0] == 2'b11) ?
                     2'b01 : r_lfsr[1:0];

  always_comb begin
    w_sum = {1'b0, r_score};
    if (w_hit[0]) w_sum = w_sum + PTS_V;
    if (w_hit[1]) w_sum = w_sum + PTS_V;
    if (w_hit[2]) w_sum = w_sum + PTS_V;
    w_score_n = (w_sum > 11'd1023) ?
                10'h3FF : w_sum[9:0];
  end

  // Input sync, key history and free-running LFSR
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_kc0  <= '0;
      r_kc1  <= '0;
      r_kc2  <= '0;
      r_pu   <= '0;
      r_ll   <= 1'b0;
      r_ll_d <= 1'b0;
      r_vs   <= 1'b1;
      r_vs_d <= 1'b1;
      r_rb   <= 1'b0;
      r_pres <= '0;
      r_lfsr <= 8'hA5;
    end else begin
      r_kc0  <= keycode;
      r_kc1  <= keycode2;
      r_kc2  <= keycode3;
      r_pu   <= {pass_up3, pass_up2, pass_up1};
      r_ll   <= lose_life;
      r_ll_d <= r_ll;
      r_vs   <= vs;
      r_vs_d <= r_vs;
      r_rb   <= reset_button;
      r_pres <= w_pres;
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= S_IDLE;
    else                r_state <= w_next;
  end

  // Lives reaching zero takes precedence over the win score
  always_comb begin
    w_next = r_state;
    if (r_rb) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_start) w_next = S_PLAY;
        S_PLAY: begin
          if (r_lives == 2'd0)     w_next = S_LOSE;
          else if (r_score >= WIN_V) w_next = S_WIN;
        end
        S_WIN:  if (w_start) w_next = S_IDLE;
        S_LOSE: if (w_start) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_score <= '0;
      r_lives <= LIVES_V;
      r_win   <= 1'b0;
      r_lose  <= 1'b0;
      r_spawn <= 1'b0;
      r_lane  <= '0;
      r_flash <= '0;
      r_fcnt  <= '0;
      r_diff  <= 1'b0;
    end else begin
      r_win   <= (r_state == S_WIN);
      r_lose  <= (r_state == S_LOSE);
      r_spawn <= 1'b0;
      r_flash <= '0;
      if (r_rb) begin
        r_score <= '0;
        r_lives <= LIVES_V;
        r_fcnt  <= '0;
      end else if (r_state == S_IDLE && w_start) begin
        r_score <= '0;
        r_lives <= LIVES_V;
        r_fcnt  <= '0;
        r_diff  <= difficulty;
      end else if (r_state == S_PLAY) begin
        r_score <= w_score_n;
        r_flash <= w_hit;
        if (w_ll_edge && r_lives != 2'd0)
          r_lives <= r_lives - 2'd1;
        if (w_tick) begin
          if (r_fcnt == w_ivl) begin
            r_fcnt  <= '0;
            r_spawn <= 1'b1;
            r_lane  <= w_lane;
          end else begin
            r_fcnt <= r_fcnt + 8'd1;
          end
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  assign score_val  = r_score;
  assign lives      = r_lives;
  assign win_game   = r_win;
  assign lose_game  = r_lose;
  assign spawn      = r_spawn;
  assign spawn_lane = r_lane;
  assign state      = r_state;
  assign hit_flash  = r_flash;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl; a second instance
// with WIN_SCORE=1023 covers score saturation.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] keycode, keycode2, keycode3;
  logic       pass_up1, pass_up2, pass_up3;
  logic       lose_life, vs, reset_button, difficulty;

  logic [9:0] score_val, s_score;
  logic [1:0] lives, s_lives;
  logic       win_game, s_win;
  logic       lose_game, s_lose;
  logic       spawn, s_spawn;
  logic [1:0] spawn_lane, s_lane;
  logic [1:0] state, s_state;
  logic [2:0] hit_flash, s_flash;

  int n_chk = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  game_flow_ctrl u_dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .keycode(keycode), .keycode2(keycode2),
    .keycode3(keycode3),
    .pass_up1(pass_up1), .pass_up2(pass_up2),
    .pass_up3(pass_up3),
    .lose_life(lose_life), .vs(vs),
    .reset_button(reset_button),
    .difficulty(difficulty),
    .score_val(score_val), .lives(lives),
    .win_game(win_game), .lose_game(lose_game),
    .spawn(spawn), .spawn_lane(spawn_lane),
    .state(state), .hit_flash(hit_flash)
  );

  game_flow_ctrl #(.WIN_SCORE(1023)) u_sat (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .keycode(keycode), .keycode2(keycode2),
    .keycode3(keycode3),
    .pass_up1(pass_up1), .pass_up2(pass_up2),
    .pass_up3(pass_up3),
    .lose_life(lose_life), .vs(vs),
    .reset_button(reset_button),
    .difficulty(difficulty),
    .score_val(s_score), .lives(s_lives),
    .win_game(s_win), .lose_game(s_lose),
    .spawn(s_spawn), .spawn_lane(s_lane),
    .state(s_state), .hit_flash(s_flash)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs;
    keycode = 0; keycode2 = 0; keycode3 = 0;
    pass_up1 = 0; pass_up2 = 0; pass_up3 = 0;
    lose_life = 0; vs = 1; reset_button = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(1);
  endtask

  task automatic start_key;
    keycode = 8'h2C;
    ticks(3);
    keycode = 8'h00;
    ticks(2);
  endtask

  task automatic hit1;
    keycode2 = 8'h04;
    ticks(2);
    keycode2 = 8'h00;
    ticks(2);
  endtask

  task automatic lose1;
    lose_life = 1'b1;
    ticks(2);
    lose_life = 1'b0;
    ticks(2);
  endtask

  int pulses, hi_cyc, bad_lane;
  logic prev_sp;

  task automatic sample_spawn;
    ticks(1);
    if (spawn) begin
      hi_cyc++;
      if (!prev_sp) pulses++;
      if (spawn_lane == 2'd3) bad_lane++;
    end
    prev_sp = spawn;
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      vs = 1'b0;
      sample_spawn();
      sample_spawn();
      vs = 1'b1;
      sample_spawn();
      sample_spawn();
    end
    for (int i = 0; i < 3; i++) sample_spawn();
  endtask

  initial begin
    difficulty = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    ticks(2);
    chk("rst_state", state, 0);
    chk("rst_score", score_val, 0);
    chk("rst_lives", lives, 3);
    chk("rst_win", win_game, 0);
    chk("rst_lose", lose_game, 0);
    chk("rst_spawn", spawn, 0);
    chk("rst_lane", spawn_lane, 0);
    chk("rst_flash", hit_flash, 0);
    rst_n = 1'b1;
    ticks(1);

    keycode = 8'h2C;
    ticks(1);
    chk("start_lat1", state, 0);
    ticks(2);
    chk("start_state", state, 1);
    chk("start_lives", lives, 3);
    chk("start_score", score_val, 0);
    ticks(4);
    chk("start_hold", state, 1);
    keycode = 8'h00;
    ticks(2);

    pass_up1 = 1'b1;
    keycode2 = 8'h04;
    ticks(1);
    chk("hit_lat1", score_val, 0);
    ticks(1);
    chk("hit_score", score_val, 10);
    chk("hit_flash", hit_flash, 3'b001);
    ticks(1);
    chk("hit_flash_off", hit_flash, 0);
    ticks(3);
    chk("hit_hold", score_val, 10);
    keycode2 = 8'h00;
    pass_up1 = 1'b0;
    ticks(2);
    keycode2 = 8'h04;
    ticks(3);
    chk("miss_score", score_val, 10);
    keycode2 = 8'h00;
    ticks(2);

    pass_up1 = 1'b1;
    pass_up3 = 1'b1;
    keycode  = 8'h04;
    keycode3 = 8'h07;
    ticks(2);
    chk("dual_score", score_val, 30);
    chk("dual_flash", hit_flash, 3'b101);
    ticks(1);
    chk("dual_once", score_val, 30);

    rst_n = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_score", score_val, 0);

    do_reset();
    start_key();
    lose1();
    chk("lives_2", lives, 2);
    lose1();
    chk("lives_1", lives, 1);
    lose_life = 1'b1;
    ticks(2);
    chk("lives_0", lives, 0);
    chk("lose_pre", state, 1);
    ticks(1);
    chk("lose_state", state, 3);
    chk("lose_flag_lat", lose_game, 0);
    ticks(1);
    chk("lose_flag", lose_game, 1);
    lose_life = 1'b0;
    ticks(2);
    lose1();
    chk("lives_floor", lives, 0);
    start_key();
    chk("lose_to_idle", state, 0);

    do_reset();
    start_key();
    lose1();
    lose1();
    pass_up1 = 1'b1;
    for (int i = 0; i < 49; i++) hit1();
    chk("s490_score", score_val, 490);
    chk("s490_state", state, 1);
    keycode2  = 8'h04;
    lose_life = 1'b1;
    ticks(2);
    chk("tie_score", score_val, 500);
    chk("tie_lives", lives, 0);
    ticks(1);
    chk("tie_state", state, 3);
    ticks(1);
    chk("tie_win", win_game, 0);
    chk("tie_lose", lose_game, 1);

    do_reset();
    difficulty = 1'b1;
    start_key();
    difficulty = 1'b0;
    pulses = 0; hi_cyc = 0; bad_lane = 0;
    prev_sp = 1'b0;
    frames(90);
    chk("sp_pulses", pulses, 3);
    chk("sp_width", hi_cyc, 3);
    chk("sp_lane", bad_lane, 0);

    do_reset();
    start_key();
    pass_up1 = 1'b1;
    for (int i = 0; i < 102; i++) hit1();
    chk("sat_pre", s_score, 1020);
    chk("sat_play", s_state, 1);
    chk("win500_state", state, 2);
    chk("win500_flag", win_game, 1);
    keycode2 = 8'h04;
    ticks(2);
    chk("sat_score", s_score, 1023);
    ticks(1);
    chk("sat_win", s_state, 2);
    ticks(1);
    chk("sat_winflag", s_win, 1);
    keycode2 = 8'h00;
    ticks(2);

    do_reset();
    start_key();
    pass_up1 = 1'b1;
    hit1();
    lose1();
    chk("rb_pre_score", score_val, 10);
    chk("rb_pre_lives", lives, 2);
    reset_button = 1'b1;
    ticks(1);
    reset_button = 1'b0;
    ticks(1);
    chk("rb_state", state, 0);
    chk("rb_score", score_val, 0);
    chk("rb_lives", lives, 3);
    difficulty = 1'b1;
    pulses = 0; hi_cyc = 0; bad_lane = 0;
    prev_sp = 1'b0;
    frames(35);
    chk("rb_nospawn", pulses, 0);
    chk("rb_idle", state, 0);

    $display("test done: total=%0d bad=%0d",
             n_chk, n_bad);
    $finish;
  end

endmodule
